// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: walks a 3x3 (KERNEL) sliding window over an image
// frame, one column of taps at a time, feeding conv_controller.
// Upstream pixels arrive on a valid/ready handshake; conv_controller's
// modwait throttles acceptance combinationally.
// Optional feature: define CONV_FRAME_SEQUENCER_ABORT_EN to add an abort input
// that drops an in-flight frame back to IDLE without a frame_done pulse.
module conv_frame_sequencer #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int KERNEL     = 3,
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          frame_start,
  input  logic          pixel_valid,
  output logic          pixel_ready,
  input  logic          modwait,
  output logic          sample_load_en,
  output logic          new_row,
  output logic [CW-1:0] col_idx,
  output logic [RW-1:0] row_idx,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun_err
`ifdef CONV_FRAME_SEQUENCER_ABORT_EN
  ,
  input  logic          abort
`endif
);

  localparam int OUT_ROWS = IMG_HEIGHT - KERNEL + 1;
  localparam int TW       = (KERNEL > 1) ? $clog2(KERNEL) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          ovr_q, ovr_d;
  logic          abort_w;
  logic          xfer;
  logic          last_tap, last_col, last_row;

`ifdef CONV_FRAME_SEQUENCER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign last_tap = (tap_q == TW'(KERNEL - 1));
  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RW'(OUT_ROWS - 1));

  assign col_idx     = col_q;
  assign row_idx     = row_q;
  assign overrun_err = ovr_q;

  // State, position counters and sticky overrun flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state, counter advance and handshake outputs.
  always_comb begin
    state_d        = state_q;
    tap_d          = tap_q;
    col_d          = col_q;
    row_d          = row_q;
    ovr_d          = ovr_q;
    pixel_ready    = 1'b0;
    sample_load_en = 1'b0;
    new_row        = 1'b0;
    frame_done     = 1'b0;
    xfer           = 1'b0;
    busy           = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = STREAM;
          tap_d   = '0;
          col_d   = '0;
          row_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      STREAM: begin
        // modwait gates acceptance in the same cycle it rises.
        pixel_ready    = !modwait;
        xfer           = pixel_valid && !modwait;
        sample_load_en = xfer;
        new_row        = xfer && (tap_q == '0) && (col_q == '0) && (row_q != '0);
        if (abort_w) begin
          // The handshake still completes, but the frame is dropped.
          state_d = IDLE;
          tap_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end else if (xfer) begin
          if (last_tap && last_col && last_row) begin
            state_d = DRAIN;
            tap_d   = '0;
            col_d   = '0;
            row_d   = '0;
          end else if (last_tap) begin
            tap_d = '0;
            if (last_col) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Wait for conv_controller to finish the last column.
        if (abort_w)       state_d = IDLE;
        else if (!modwait) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start request while a frame is in flight is dropped and flagged.
    if (frame_start && (state_q != IDLE)) ovr_d = 1'b1;
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer (4x4 image, 3-tap kernel).
// The reference model tracks a frame phase and the number of transfers
// done so far; expected tap/column/row are derived arithmetically from it.
module tb_conv_frame_sequencer;
  localparam int W = 4, H = 4, K = 3;
  localparam int OR = H - K + 1;
  localparam int TOTAL = K * W * OR;
  localparam int P_IDLE = 0, P_STREAM = 1, P_DRAIN = 2, P_DONE = 3;

  logic clk = 1'b0, n_rst = 1'b0;
  logic frame_start = 1'b0, pixel_valid = 1'b0, modwait = 1'b0;
  logic pixel_ready, sample_load_en, new_row, busy, frame_done, overrun_err;
  logic [1:0] col_idx, row_idx;
`ifdef CONV_FRAME_SEQUENCER_ABORT_EN
  logic abort = 1'b0;
`endif

  conv_frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K)) dut (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .modwait(modwait),
    .sample_load_en(sample_load_en), .new_row(new_row),
    .col_idx(col_idx), .row_idx(row_idx), .busy(busy),
    .frame_done(frame_done), .overrun_err(overrun_err)
`ifdef CONV_FRAME_SEQUENCER_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int ph = P_IDLE, k = 0;
  bit ovr = 1'b0, prev_load = 1'b0;
  int dut_loads = 0, dut_nr = 0, dut_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, check at negedge against the model, advance model.
  task automatic cyc(input bit fs, input bit pv, input bit mw, input bit ab);
    bit el, enr, abt;
    frame_start = fs; pixel_valid = pv; modwait = mw;
`ifdef CONV_FRAME_SEQUENCER_ABORT_EN
    abort = ab;
    abt = ab;
`else
    abt = 1'b0;
`endif
    @(negedge clk);
    if (!n_rst) begin ph = P_IDLE; k = 0; ovr = 1'b0; end
    el  = (ph == P_STREAM) && !mw && pv;
    enr = el && (k % (K * W) == 0) && (k != 0);
    chk("pixel_ready", pixel_ready, (ph == P_STREAM) && !mw);
    chk("sample_load_en", sample_load_en, el);
    chk("new_row", new_row, enr);
    chk("col_idx", col_idx, (k / K) % W);
    chk("row_idx", row_idx, k / (K * W));
    chk("busy", busy, ph != P_IDLE);
    chk("frame_done", frame_done, ph == P_DONE);
    chk("overrun_err", overrun_err, ovr);
    dut_loads += int'(sample_load_en);
    dut_nr    += int'(new_row);
    dut_done  += int'(frame_done);
    prev_load = el;
    if (n_rst) begin
      if (ph != P_IDLE && fs) ovr = 1'b1;
      case (ph)
        P_IDLE: if (fs) begin ph = P_STREAM; k = 0; ovr = 1'b0; end
        P_STREAM: begin
          if (abt) begin ph = P_IDLE; k = 0; end
          else if (el) begin
            k++;
            if (k == TOTAL) begin k = 0; ph = P_DRAIN; end
          end
        end
        P_DRAIN: if (abt) ph = P_IDLE; else if (!mw) ph = P_DONE;
        default: ph = P_IDLE;
      endcase
    end
    @(posedge clk); #1;
  endtask

  // Runs one frame; mode 0 = controller-like modwait, 1 = random, 2 = directed stalls.
  task automatic run_frame(input int mode);
    int cycles, stall, gap;
    bit fs, pv, mw;
    cycles = 0; stall = 0; gap = 0;
    dut_loads = 0; dut_nr = 0; dut_done = 0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    while (ph != P_IDLE && cycles < 1000) begin
      fs = 1'b0; pv = 1'b1; mw = 1'b0;
      case (mode)
        0: mw = prev_load;
        1: begin
          pv = ($urandom % 4) != 0;
          mw = ($urandom % 3) == 0;
          fs = (cycles == 20);
        end
        default: begin
          if (ph == P_STREAM && k == 3 && stall < 6) begin mw = 1'b1; stall++; end
          else if (ph == P_STREAM && k == 7 && gap < 10) begin pv = 1'b0; gap++; end
          fs = (ph == P_STREAM) && (k == TOTAL - 1);
        end
      endcase
      cyc(fs, pv, mw, 1'b0);
      cycles++;
    end
    chk("frame_timeout", cycles < 1000, 1);
    chk("loads_per_frame", dut_loads, TOTAL);
    chk("new_row_count", dut_nr, 1);
    chk("frame_done_count", dut_done, 1);
  endtask

  initial begin
    int guard;
    // Reset state
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    n_rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back loads spaced by a one-cycle modwait
    run_frame(0);

    // Asynchronous reset mid-stream after 5 transfers
    dut_done = 0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (k < 5 && guard < 100) begin cyc(1'b0, 1'b1, prev_load, 1'b0); guard++; end
    chk("reset_prep_timeout", guard < 100, 1);
    n_rst = 1'b0;
    #1;
    chk("async_reset_busy", busy, 0);
    chk("async_reset_col", col_idx, 0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    n_rst = 1'b1;
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset_no_frame_done", dut_done, 0);

    // Long modwait stall, pixel_valid gap, frame_start on the final transfer
    run_frame(2);
    chk("overrun_sticky_idle", overrun_err, 1);

    // Randomized frames with a stray frame_start mid-frame
    repeat (4) run_frame(1);
    chk("overrun_after_random", overrun_err, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef CONV_FRAME_SEQUENCER_ABORT_EN
    dut_done = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (k < 10 && guard < 100) begin cyc(1'b0, 1'b1, prev_load, 1'b0); guard++; end
    chk("abort_prep_timeout", guard < 100, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("abort_no_frame_done", dut_done, 0);
    run_frame(0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
